// File: rtl/bram_snapshot_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_snapshot_writer_pkg
// Purpose  : Shared definitions for the BRAM snapshot writer.
//            - Capture state encoding.
//            - Helper that derives the BRAM depth from an address width.
// Revision : 1.0 - initial release
// ============================================================================
package bram_snapshot_writer_pkg;

    localparam int          c_STATE_W   = 2;
    localparam logic [1:0]  c_ST_IDLE    = 2'd0;
    localparam logic [1:0]  c_ST_ARMED   = 2'd1;
    localparam logic [1:0]  c_ST_CAPTURE = 2'd2;
    localparam logic [1:0]  c_ST_DONE    = 2'd3;

    // DEPTH = 2**ADDR_WIDTH
    function automatic int snap_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_snapshot_writer_counter.sv
`default_nettype none
// ============================================================================
// Module   : snapshot_addr_counter
// Purpose  : Wrapping WIDTH-bit up-counter.
//            - Synchronous clear.
//            - Count enable.
//            - Terminal-value flag.
//            Used both for the BRAM write address and for the post-trigger
//            sample count.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            i_clr      - return count to zero (priority over i_en)
//            i_en       - advance count by one, modulo 2**WIDTH
//            o_count    - current count
//            o_last     - high while o_count == LAST_VALUE
// Revision : 1.0 - initial release
// ============================================================================
module snapshot_addr_counter
    import bram_snapshot_writer_pkg::*;
#(
    parameter int               WIDTH      = 10,
    parameter logic [WIDTH-1:0] LAST_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_last
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == LAST_VALUE);

endmodule
`default_nettype wire

// File: rtl/bram_snapshot_writer.sv
`default_nettype none
// ============================================================================
// Module   : bram_snapshot_writer
// Purpose  : Captures a contiguous snapshot of a sample stream into the
//            fabric port of a dual-port BRAM.
//            - Waits for arm, then for trigger.
//            - Raises done once the last write has landed.
//            Optional macro SNAPSHOT_PRETRIGGER_EN enables pre-trigger mode:
//            - While armed, every valid sample fills a free-running ring.
//            - After the trigger, POST_SAMPLES samples are written.
//            - trig_addr reports where the trigger sample landed.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            din/din_valid   - input sample stream
//            arm             - start a new capture (from IDLE or DONE)
//            trigger         - capture trigger, qualified with the stream
//            bram_din/addr/we- registered BRAM write port
//            busy            - ARMED or CAPTURE
//            done            - snapshot complete, held until arm or rst
//            trig_addr       - trigger sample address (macro build only)
// Revision : 1.0 - initial release
// ============================================================================
module bram_snapshot_writer
    import bram_snapshot_writer_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 10,
    parameter int POST_SAMPLES = 2**(ADDR_WIDTH-1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  arm,
    input  logic                  trigger,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_we,
    output logic                  busy,
    output logic                  done
`ifdef SNAPSHOT_PRETRIGGER_EN
    ,
    output logic [ADDR_WIDTH-1:0] trig_addr
`endif
);

    localparam int c_DEPTH = snap_depth(ADDR_WIDTH);

    if (POST_SAMPLES < 1 || POST_SAMPLES > c_DEPTH) begin : g_post_samples_range
        $error("bram_snapshot_writer: POST_SAMPLES out of range 1..2**ADDR_WIDTH");
    end

    logic [c_STATE_W-1:0]  r_state;
    logic [c_STATE_W-1:0]  w_state_next;
    logic [DATA_WIDTH-1:0] r_bram_din;
    logic [ADDR_WIDTH-1:0] r_bram_addr;
    logic                  r_bram_we;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_arm_accept;
    logic                  w_write;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_addr_last;

    snapshot_addr_counter #(
        .WIDTH      (ADDR_WIDTH),
        .LAST_VALUE ({ADDR_WIDTH{1'b1}})
    ) u_addr_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_arm_accept),
        .i_en    (w_write),
        .o_count (w_addr),
        .o_last  (w_addr_last)
    );

`ifdef SNAPSHOT_PRETRIGGER_EN
    localparam logic [ADDR_WIDTH-1:0] c_POST_LAST = ADDR_WIDTH'(POST_SAMPLES - 1);

    logic                  w_post_en;
    logic                  w_trig_latch;
    logic [ADDR_WIDTH-1:0] w_post_count;
    logic                  w_post_last;
    logic [ADDR_WIDTH-1:0] r_trig_addr;
    logic                  w_addr_last_unused;

    // The ring address wraps freely in this mode, so the terminal flag of
    // the address counter has no role here.
    assign w_addr_last_unused = w_addr_last;

    // Counts post-trigger samples already written, trigger sample included.
    snapshot_addr_counter #(
        .WIDTH      (ADDR_WIDTH),
        .LAST_VALUE (c_POST_LAST)
    ) u_post_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_arm_accept),
        .i_en    (w_post_en),
        .o_count (w_post_count),
        .o_last  (w_post_last)
    );
`endif

    // ------------------------------------------------------------------
    // Next-state and write decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_arm_accept = 1'b0;
        w_write      = 1'b0;
`ifdef SNAPSHOT_PRETRIGGER_EN
        w_post_en    = 1'b0;
        w_trig_latch = 1'b0;
`endif
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                // A trigger arriving alongside arm is deliberately dropped.
                if (arm) begin
                    w_arm_accept = 1'b1;
                    w_state_next = c_ST_ARMED;
                end
            end
            c_ST_ARMED: begin
`ifdef SNAPSHOT_PRETRIGGER_EN
                w_write = din_valid;
                if (trigger) begin
                    w_post_en    = din_valid;
                    w_trig_latch = din_valid;
                    if (din_valid && w_post_last) begin
                        w_state_next = c_ST_DONE;
                    end else begin
                        w_state_next = c_ST_CAPTURE;
                    end
                end
`else
                if (trigger) begin
                    w_write      = din_valid;
                    w_state_next = c_ST_CAPTURE;
                end
`endif
            end
            c_ST_CAPTURE: begin
                w_write = din_valid;
`ifdef SNAPSHOT_PRETRIGGER_EN
                w_post_en = din_valid;
                // Trigger arrived without a valid sample: the first valid
                // sample in CAPTURE stands in as the trigger sample.
                w_trig_latch = din_valid && (w_post_count == '0);
                if (din_valid && w_post_last) begin
                    w_state_next = c_ST_DONE;
                end
`else
                if (din_valid && w_addr_last) begin
                    w_state_next = c_ST_DONE;
                end
`endif
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bram_we <= w_write;
            if (w_write) begin
                r_bram_addr <= w_addr;
                r_bram_din  <= din;
            end
            r_busy <= (w_state_next == c_ST_ARMED) || (w_state_next == c_ST_CAPTURE);
            // done trails the DONE state by one cycle so that the final
            // strobe has already been presented to the BRAM.
            r_done <= (r_state == c_ST_DONE) && !w_arm_accept;
        end
    end

`ifdef SNAPSHOT_PRETRIGGER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_addr <= '0;
        end else if (w_trig_latch) begin
            r_trig_addr <= w_addr;
        end
    end

    assign trig_addr = r_trig_addr;
`endif

    assign bram_din  = r_bram_din;
    assign bram_addr = r_bram_addr;
    assign bram_we   = r_bram_we;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
